// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN post-processing datapath: default widths,
// int8 limits and the pooling-stage state encoding.
package cnn_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_OUT_W  = 8;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVEN_ROW = 2'd1,
    ODD_ROW  = 2'd2,
    ERR      = 2'd3
  } pool_state_t;

endpackage

// File: rtl/relu_sat8.sv
// Combinational optional ReLU followed by signed saturation from IN_W to OUT_W.
// Shared with the fully-connected path, so it is kept free of pooling state.
module relu_sat8
  import cnn_pkg::*;
#(
  parameter int IN_W  = DEF_DATA_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [IN_W-1:0]  din,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] dout
);

  localparam int MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam int MIN_I = -(1 << (OUT_W - 1));
  localparam logic signed [IN_W-1:0]  MAX_IN  = IN_W'(MAX_I);
  localparam logic signed [IN_W-1:0]  MIN_IN  = IN_W'(MIN_I);
  localparam logic signed [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_I);
  localparam logic signed [OUT_W-1:0] MIN_OUT = OUT_W'(MIN_I);

  always_comb begin
    dout = din[OUT_W-1:0];
    if (relu_en && din < 0) begin
      dout = '0;
    end else if (din > MAX_IN) begin
      dout = MAX_OUT;
    end else if (din < MIN_IN) begin
      dout = MIN_OUT;
    end
  end

endmodule

// File: rtl/relu_sat_maxpool.sv
// ReLU + int8 saturation followed by 2x2 stride-2 max pooling over a raster
// stream, using one half-row line buffer of horizontal pair maxima.
module relu_sat_maxpool
  import cnn_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int MAX_COLS = 64,
  parameter int COL_W    = $clog2(MAX_COLS) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COL_W-1:0]         cfg_cols,
  input  logic                     relu_en,
  input  logic                     valid_in,
  input  logic                     sof_in,
  input  logic signed [DATA_W-1:0] din,
  output logic                     valid_out,
  output logic signed [OUT_W-1:0]  dout,
  output logic                     eol_out,
  output logic                     cfg_err
);

  localparam int HALF  = MAX_COLS / 2;
  localparam int IDX_W = $clog2(HALF);

  pool_state_t state, state_n;
  logic [COL_W-1:0] col, col_n, cols_q, cols_n;
  logic relu_q, relu_n, err_n;
  logic signed [OUT_W-1:0] pair_reg, x, h, pooled;
  logic signed [OUT_W-1:0] line_buf [HALF];
  logic [IDX_W-1:0] idx;
  logic start, cfg_ok, last, relu_sel;
  logic load_pair, store, emit, eol_n;

  // The sof sample is transformed with the relu_en being latched on that same edge.
  assign start    = valid_in && sof_in;
  assign relu_sel = start ? relu_en : relu_q;
  assign cfg_ok   = (cfg_cols != '0) && !cfg_cols[0] && (cfg_cols <= COL_W'(MAX_COLS));
  assign last     = (col == cols_q - COL_W'(1));
  assign idx      = col[IDX_W:1];

  relu_sat8 #(.IN_W(DATA_W), .OUT_W(OUT_W)) u_relu_sat8 (
    .din     (din),
    .relu_en (relu_sel),
    .dout    (x)
  );

  assign h      = (pair_reg > x) ? pair_reg : x;
  assign pooled = (h > line_buf[idx]) ? h : line_buf[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      cols_q    <= '0;
      relu_q    <= 1'b0;
      cfg_err   <= 1'b0;
      pair_reg  <= '0;
      valid_out <= 1'b0;
      eol_out   <= 1'b0;
      dout      <= '0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      cols_q    <= cols_n;
      relu_q    <= relu_n;
      cfg_err   <= err_n;
      valid_out <= emit;
      eol_out   <= eol_n;
      if (load_pair) pair_reg <= x;
      if (emit) dout <= pooled;
    end
  end

  // Line buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (store) line_buf[idx] <= h;
  end

  always_comb begin
    state_n   = state;
    col_n     = col;
    cols_n    = cols_q;
    relu_n    = relu_q;
    err_n     = cfg_err;
    load_pair = 1'b0;
    store     = 1'b0;
    emit      = 1'b0;
    eol_n     = 1'b0;
    if (start) begin
      cols_n = cfg_cols;
      relu_n = relu_en;
      if (cfg_ok) begin
        state_n   = EVEN_ROW;
        err_n     = 1'b0;
        col_n     = COL_W'(1);
        load_pair = 1'b1;
      end else begin
        state_n = ERR;
        err_n   = 1'b1;
        col_n   = '0;
      end
    end else if (valid_in && (state == EVEN_ROW || state == ODD_ROW)) begin
      if (last) begin
        col_n   = '0;
        state_n = (state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
      end else begin
        col_n = col + COL_W'(1);
      end
      if (!col[0]) begin
        load_pair = 1'b1;
      end else if (state == EVEN_ROW) begin
        store = 1'b1;
      end else begin
        emit  = 1'b1;
        eol_n = last;
      end
    end
  end

endmodule

// File: tb/tb_relu_sat_maxpool.sv
// Scoreboard bench: the driver queues hand-computed pooled outputs with the cycle
// they are due, and a negedge monitor pops and compares each DUT output pulse.
module tb_relu_sat_maxpool;

  localparam int COL_W = 7;

  logic clk = 1'b0;
  logic rst;
  logic [COL_W-1:0] cfg_cols;
  logic relu_en, valid_in, sof_in;
  logic signed [15:0] din;
  logic valid_out, eol_out, cfg_err;
  logic signed [7:0] dout;

  typedef struct {
    int d;
    int e;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pushed = 0;
  int seen = 0;

  logic signed [15:0] s1 [8] = '{16'sd10, 16'sd200, -16'sd5, 16'sd3,
                                 16'sd50, -16'sd300, 16'sd7, 16'sd2};

  relu_sat_maxpool dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_cols  (cfg_cols),
    .relu_en   (relu_en),
    .valid_in  (valid_in),
    .sof_in    (sof_in),
    .din       (din),
    .valid_out (valid_out),
    .dout      (dout),
    .eol_out   (eol_out),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one sample for one cycle, optionally queueing the output it completes.
  task automatic applyStimulus(input bit sof, input logic signed [15:0] d,
                               input bit has_exp, input int exp_d, input int exp_e,
                               input int gap);
    exp_t e;
    valid_in = 1'b1;
    sof_in   = sof;
    din      = d;
    if (has_exp) begin
      e.d = exp_d;
      e.e = exp_e;
      e.c = cyc + 1;
      exp_q.push_back(e);
      pushed++;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic runScenario1(input int gap, input bit relu);
    cfg_cols = 7'd4;
    relu_en  = relu;
    for (int i = 0; i < 8; i++)
      applyStimulus(i == 0, s1[i], (i == 5) || (i == 7), (i == 5) ? 127 : 7, (i == 7) ? 1 : 0, gap);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid_out === 1'b1) begin
      seen++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("dout", int'(dout), e.d);
        checkOutput("eol_out", int'(eol_out), e.e);
        checkOutput("latency_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_cols = '0; relu_en = 1'b0;
    valid_in = 1'b0; sof_in = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_valid_out", int'(valid_out), 0);
    checkOutput("reset_dout", int'(dout), 0);
    checkOutput("reset_eol_out", int'(eol_out), 0);
    checkOutput("reset_cfg_err", int'(cfg_err), 0);

    $display("[TB] scenario 1: cols=4 relu on");
    runScenario1(0, 1'b1);
    $display("[TB] scenario 2: cols=4 relu off");
    runScenario1(0, 1'b0);

    $display("[TB] scenario 3: cols=2 negatives");
    cfg_cols = 7'd2; relu_en = 1'b0;
    applyStimulus(1, -16'sd1000, 0, 0, 0, 0);
    applyStimulus(0, -16'sd2, 0, 0, 0, 0);
    applyStimulus(0, -16'sd5, 0, 0, 0, 0);
    applyStimulus(0, -16'sd6, 1, -2, 1, 0);
    relu_en = 1'b1;
    applyStimulus(1, -16'sd1000, 0, 0, 0, 0);
    applyStimulus(0, -16'sd2, 0, 0, 0, 0);
    applyStimulus(0, -16'sd5, 0, 0, 0, 0);
    applyStimulus(0, -16'sd6, 1, 0, 1, 0);

    $display("[TB] scenario 4: gaps of 3 cycles");
    runScenario1(3, 1'b1);

    $display("[TB] scenario 5: illegal cols then recovery");
    cfg_cols = 7'd5; relu_en = 1'b1;
    for (int i = 0; i < 8; i++)
      applyStimulus(i == 0, 16'(i * 10), 0, 0, 0, 0);
    checkOutput("cfg_err_set", int'(cfg_err), 1);
    runScenario1(0, 1'b1);
    checkOutput("cfg_err_clear", int'(cfg_err), 0);

    $display("[TB] scenario 6: reset mid-frame");
    cfg_cols = 7'd4; relu_en = 1'b1;
    for (int i = 0; i < 6; i++)
      applyStimulus(i == 0, s1[i], i == 5, 127, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_mid_valid_out", int'(valid_out), 0);
    checkOutput("rst_mid_cfg_err", int'(cfg_err), 0);
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 16'sd100, 0, 0, 0, 0);
    runScenario1(0, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("output_count", seen, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
